// File: rtl/pc_stack_if.sv
// pc_stack_if: request/status bundle for the program-counter stack.
// master drives in/load/branch/call/ret/inc/err_clr; slave returns out/level/empty/full/overflow/underflow.
interface pc_stack_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] in;
   logic             load;
   logic             branch;
   logic             call;
   logic             ret;
   logic             inc;
   logic             err_clr;
   logic [WIDTH-1:0] out;
   logic [LW-1:0]    level;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output in,
      output load,
      output branch,
      output call,
      output ret,
      output inc,
      output err_clr,
      input  out,
      input  level,
      input  empty,
      input  full,
      input  overflow,
      input  underflow
   );

   modport slave (
      input  in,
      input  load,
      input  branch,
      input  call,
      input  ret,
      input  inc,
      input  err_clr,
      output out,
      output level,
      output empty,
      output full,
      output overflow,
      output underflow
   );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: program counter with load/branch/call/ret/inc and a return-address stack.
// Ports: clk, reset (async active-low), bus (pc_stack_if.slave: requests in, counter/stack status out).
module pc_stack #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 8,
   parameter int               STEP      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic       clk,
   input logic       reset,
   pc_stack_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [LW-1:0]    FULL_L = LW'(DEPTH);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [LW-1:0]    lvl_q;
   logic [LW-1:0]    lvl_d;
   logic [LW-1:0]    lvl_m1;
   logic             ovf_q;
   logic             ovf_d;
   logic             unf_q;
   logic             unf_d;
   logic             emp;
   logic             ful;
   logic             push;
   logic             ovf_set;
   logic             unf_set;
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] top;

   logic [WIDTH-1:0] stk [DEPTH];

   // One-hot winner of the fixed-priority request chain.
   logic sel_load;
   logic sel_br;
   logic sel_call;
   logic sel_ret;
   logic sel_inc;
   logic sel_hold;

   assign sel_load = bus.load;
   assign sel_br   = bus.branch & ~bus.load;
   assign sel_call = bus.call & ~bus.branch
                   & ~bus.load;
   assign sel_ret  = bus.ret & ~bus.call
                   & ~bus.branch & ~bus.load;
   assign sel_inc  = bus.inc & ~bus.ret
                   & ~bus.call & ~bus.branch
                   & ~bus.load;
   assign sel_hold = ~(bus.inc | bus.ret
                   | bus.call | bus.branch
                   | bus.load);

   assign emp      = (lvl_q == '0);
   assign ful      = (lvl_q == FULL_L);
   assign lvl_m1   = lvl_q - 1'b1;
   assign ret_addr = pc_q + STEP_W;
   assign top      = stk[lvl_m1[AW-1:0]];

   always_comb begin
      pc_d    = pc_q;
      lvl_d   = lvl_q;
      push    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      unique case (1'b1)
         sel_load: pc_d = bus.in;
         sel_br:   pc_d = pc_q + bus.in;
         sel_call: begin
            pc_d = bus.in;
            if (ful) begin
               ovf_set = 1'b1;
            end else begin
               push  = 1'b1;
               lvl_d = lvl_q + 1'b1;
            end
         end
         sel_ret: begin
            if (emp) begin
               unf_set = 1'b1;
            end else begin
               pc_d  = top;
               lvl_d = lvl_m1;
            end
         end
         sel_inc:  pc_d = pc_q + STEP_W;
         sel_hold: pc_d = pc_q;
         default:  pc_d = pc_q;
      endcase
   end

   // A fresh error in the err_clr cycle wins over the clear.
   assign ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
   assign unf_d = unf_set | (unf_q & ~bus.err_clr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_VAL;
         lvl_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         lvl_q <= lvl_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Entries at or above level are never read, so storage needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stk[lvl_q[AW-1:0]] <= ret_addr;
      end
   end

   assign bus.out       = pc_q;
   assign bus.level     = lvl_q;
   assign bus.empty     = emp;
   assign bus.full      = ful;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed bench for pc_stack with a reference model and expected-value queue.
// Drives the master side of pc_stack_if; compares each cycle's registered outputs.
module tb_pc_stack;
   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int STEP  = 1;
   localparam int LW    = $clog2(DEPTH) + 1;

   typedef struct {
      string            tag;
      logic [WIDTH-1:0] out;
      logic [LW-1:0]    lvl;
      logic             emp;
      logic             ful;
      logic             ovf;
      logic             unf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   int tests = 0;
   int fails = 0;

   exp_t             exp_q [$];
   logic [WIDTH-1:0] m_stk [$];
   logic [WIDTH-1:0] m_pc;
   logic             m_ovf;
   logic             m_unf;

   pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   pc_stack #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .STEP(STEP),
      .RESET_VAL('0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h",
                tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_pc  = '0;
      m_stk = {};
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic idle();
      bus.in      = '0;
      bus.load    = 1'b0;
      bus.branch  = 1'b0;
      bus.call    = 1'b0;
      bus.ret     = 1'b0;
      bus.inc     = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".out"}, 32'(bus.out), 32'(e.out));
      chk({tag, ".lvl"}, 32'(bus.level), 32'(e.lvl));
      chk({tag, ".emp"}, 32'(bus.empty), 32'(e.emp));
      chk({tag, ".ful"}, 32'(bus.full), 32'(e.ful));
      chk({tag, ".ovf"}, 32'(bus.overflow), 32'(e.ovf));
      chk({tag, ".unf"}, 32'(bus.underflow), 32'(e.unf));
   endtask

   function automatic exp_t m_snap(input string tag);
      exp_t e;
      e.tag = tag;
      e.out = m_pc;
      e.lvl = LW'(m_stk.size());
      e.emp = (m_stk.size() == 0);
      e.ful = (m_stk.size() == DEPTH);
      e.ovf = m_ovf;
      e.unf = m_unf;
      return e;
   endfunction

   task automatic step(input string tag,
                       input logic [WIDTH-1:0] din,
                       input bit l, input bit b,
                       input bit c, input bit r,
                       input bit i, input bit e);
      bit   os;
      bit   us;
      exp_t x;
      bus.in      = din;
      bus.load    = l;
      bus.branch  = b;
      bus.call    = c;
      bus.ret     = r;
      bus.inc     = i;
      bus.err_clr = e;
      os = 1'b0;
      us = 1'b0;
      if (l) begin
         m_pc = din;
      end else if (b) begin
         m_pc = m_pc + din;
      end else if (c) begin
         if (m_stk.size() == DEPTH) os = 1'b1;
         else m_stk.push_back(m_pc + WIDTH'(STEP));
         m_pc = din;
      end else if (r) begin
         if (m_stk.size() == 0) us = 1'b1;
         else m_pc = m_stk.pop_back();
      end else if (i) begin
         m_pc = m_pc + WIDTH'(STEP);
      end
      m_ovf = os | (m_ovf & ~e);
      m_unf = us | (m_unf & ~e);
      exp_q.push_back(m_snap(tag));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         x = exp_q.pop_front();
         chk_all(x.tag, x);
      end
      idle();
   endtask

   initial begin
      exp_t rz;
      rz.tag = "rst";
      rz.out = '0;
      rz.lvl = '0;
      rz.emp = 1'b1;
      rz.ful = 1'b0;
      rz.ovf = 1'b0;
      rz.unf = 1'b0;

      idle();
      m_reset();
      bus.in   = 16'h1234;
      bus.load = 1'b1;
      bus.inc  = 1'b1;
      reset    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("rst_hold", rz);
      idle();
      reset = 1'b1;

      for (int k = 0; k < 4; k++) step("inc", '0, 0, 0, 0, 0, 1, 0);
      chk("inc4", 32'(bus.out), 32'h4);

      step("hold", 16'h5555, 0, 0, 0, 0, 0, 0);

      step("ld10", 16'h0010, 1, 0, 0, 0, 0, 0);
      step("call1", 16'h0100, 0, 0, 1, 0, 0, 0);
      step("call2", 16'h0200, 0, 0, 1, 0, 0, 0);
      step("ret1", '0, 0, 0, 0, 1, 0, 0);
      chk("ret1k", 32'(bus.out), 32'h0101);
      step("ret2", '0, 0, 0, 0, 1, 0, 0);
      chk("ret2k", 32'(bus.out), 32'h0011);

      step("ld0", 16'h0000, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < DEPTH; k++)
         step("fill", 16'h1000 + 16'(k * 16), 0, 0, 1, 0, 0, 0);
      step("call9", 16'h0ABC, 0, 0, 1, 0, 0, 0);
      chk("c9.out", 32'(bus.out), 32'h0ABC);
      chk("c9.ovf", 32'(bus.overflow), 32'h1);
      chk("c9.lvl", 32'(bus.level), 32'h8);
      for (int k = 0; k < DEPTH; k++)
         step("drain", '0, 0, 0, 0, 1, 0, 0);
      chk("drain.out", 32'(bus.out), 32'h0001);
      step("clr_o", '0, 0, 0, 0, 0, 0, 1);

      step("ld5", 16'h0005, 1, 0, 0, 0, 0, 0);
      step("unf1", '0, 0, 0, 0, 1, 0, 0);
      chk("unf1k", 32'(bus.underflow), 32'h1);
      step("unf_clr", '0, 0, 0, 0, 1, 0, 1);
      chk("unfclrk", 32'(bus.underflow), 32'h1);
      step("clr_u", '0, 0, 0, 0, 0, 0, 1);

      step("ld20", 16'h0020, 1, 0, 0, 0, 0, 0);
      step("brneg", 16'hFFF0, 0, 1, 0, 0, 0, 0);
      chk("brk", 32'(bus.out), 32'h0010);
      step("prio", 16'h1234, 1, 1, 0, 0, 1, 0);
      step("br_vs", 16'h0004, 0, 1, 1, 1, 1, 0);
      step("ret_vs", '0, 0, 0, 0, 1, 1, 0);
      step("clr_u2", '0, 0, 0, 0, 0, 0, 1);
      step("ldff", 16'hFFFF, 1, 0, 0, 0, 0, 0);
      step("wrap", '0, 0, 0, 0, 0, 1, 0);
      chk("wrapk", 32'(bus.out), 32'h0000);

      for (int k = 0; k < DEPTH; k++)
         step("fill2", 16'h2000 + 16'(k), 0, 0, 1, 0, 0, 0);
      step("ovf2", 16'h3000, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 5; k++)
         step("pop5", '0, 0, 0, 0, 1, 0, 0);
      chk("l3", 32'(bus.level), 32'h3);

      #2;
      reset = 1'b0;
      #1;
      chk_all("midrst", rz);
      m_reset();
      #2;
      reset = 1'b1;
      step("rst_ret", '0, 0, 0, 0, 1, 0, 0);
      chk("rstretk", 32'(bus.underflow), 32'h1);

      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end
endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the counter, address and stack-entry width in bits (WIDTH >= 2).
REQ-002 Parameter DEPTH, default 8, SHALL set the number of return-address stack entries (power of two, >= 2).
REQ-003 Parameter STEP, default 1, SHALL set the increment applied by inc and the return offset pushed by call.
REQ-004 Parameter RESET_VAL, default 0, SHALL set the counter value after reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset; 0 SHALL force the reset state immediately, independent of clk.
REQ-007 Port in, input, WIDTH: absolute target for load and call, or two's-complement offset for branch.
REQ-008 Ports load, branch, call, ret, inc, input, 1 bit each: operation requests.
REQ-009 Port err_clr, input, 1 bit: clears the sticky error flags.
REQ-010 Port out, output, WIDTH: current counter value, registered.
REQ-011 Port level, output, log2(DEPTH)+1 bits: number of valid stack entries.
REQ-012 Ports empty, full, output, 1 bit each: level==0 and level==DEPTH respectively.
REQ-013 Ports overflow, underflow, output, 1 bit each: sticky error flags, registered.

Function
REQ-014 Exactly one operation SHALL execute per cycle, chosen by fixed priority: load > branch > call > ret > inc > hold.
REQ-015 load SHALL set out(t+1) = in(t); stack unchanged.
REQ-016 branch SHALL set out(t+1) = out(t) + sign-extended in(t), modulo 2^WIDTH; stack unchanged.
REQ-017 inc SHALL set out(t+1) = out(t) + STEP, modulo 2^WIDTH; wrap from 2^WIDTH-STEP to 0 SHALL NOT raise any flag.
REQ-018 hold (no request) SHALL keep out, stack and level unchanged.
REQ-019 call with full==0 SHALL push out(t)+STEP (modulo 2^WIDTH) onto the stack, increment level, and set out(t+1) = in(t).
REQ-020 call with full==1 SHALL still set out(t+1) = in(t), SHALL leave stack contents and level unchanged, and SHALL set overflow.
REQ-021 ret with empty==0 SHALL set out(t+1) to the top entry and decrement level (LIFO order).
REQ-022 ret with empty==1 SHALL hold out, leave level at 0, and set underflow.
REQ-023 Requests of lower priority asserted in the same cycle as a higher one SHALL have no effect, including on flags.
REQ-024 overflow and underflow SHALL remain 1 until err_clr or reset; err_clr SHALL clear both on the next edge, and if a new error occurs in the same cycle as err_clr, the new error SHALL win (flag = 1).
REQ-025 empty, full and level SHALL be derived from registered state only, with no combinational path from any input.
REQ-026 out SHALL change only on a clk rising edge or on reset assertion; latency of every operation SHALL be one cycle.
REQ-027 Stack storage SHALL be a register array indexed by level; entries above level are don't-care and SHALL NOT be observable.

Reset
REQ-028 reset==0 SHALL asynchronously set out=RESET_VAL, level=0, empty=1, full=0, overflow=0, underflow=0.
REQ-029 While reset==0 all requests SHALL be ignored; the first operation SHALL take effect on the first rising edge with reset==1.
REQ-030 Reset asserted mid-sequence (stack partially filled) SHALL discard all stack contents; a subsequent ret SHALL report underflow.

Verification
REQ-031 Defaults; reset low, then 4 cycles of inc -> out 0,1,2,3,4; level 0, empty 1.
REQ-032 out=0x0010; call in=0x0100; call in=0x0200; ret; ret -> out 0x0100, 0x0200, 0x0101, 0x0011; level 1,2,1,0.
REQ-033 8 calls from out=0, then a 9th call in=0x0ABC -> out=0x0ABC, level 8, full 1, overflow 1; 8 rets then return the 8 pushed addresses in reverse order.
REQ-034 Empty stack, out=0x0005, ret -> out 0x0005, underflow 1; err_clr together with a second ret -> underflow stays 1; err_clr alone -> 0.
REQ-035 out=0x0020, branch in=0xFFF0 -> out 0x0010; load=1, branch=1, inc=1, in=0x1234 -> out 0x1234, no stack change; out=0xFFFF, inc -> 0x0000, no flag.
REQ-036 Level 3, overflow 1; assert reset between clock edges -> out=0, level=0, overflow=0 before the next edge; the following ret -> underflow 1.
